// File: rtl/avalon_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single Avalon-MM master.
// One transaction at a time: IDLE -> GRANT (wait out waitrequest) -> RESP (one-cycle ack).
module avalon_bus_arbiter #(
    parameter int ROUND_ROBIN  = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               grant_d_q, grant_d_d;
    logic               last_d_q, last_d_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        address_q, address_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [31:0]        writedata_q, writedata_d;
    logic [3:0]         byteenable_q, byteenable_d;
    logic               i_ack_q, i_ack_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic               d_ack_q, d_ack_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic               pick_d;
    logic               timed_out;

    // D wins when it is the only requester, under fixed priority, or when I was served last.
    assign pick_d    = d_req && (!i_req || (ROUND_ROBIN == 0) || !last_d_q);
    assign timed_out = (WAIT_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        grant_d_d     = grant_d_q;
        last_d_d      = last_d_q;
        wait_cnt_d    = wait_cnt_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        i_ack_d       = 1'b0;
        i_rdata_d     = i_rdata_q;
        d_ack_d       = 1'b0;
        d_rdata_d     = d_rdata_q;
        busy_d        = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d_d    = pick_d;
                    last_d_d     = pick_d;
                    address_d    = pick_d ? d_addr : i_addr;
                    writedata_d  = pick_d ? d_wdata : writedata_q;
                    byteenable_d = pick_d ? d_byteenable : 4'hF;
                    read_d       = !(pick_d && d_write);
                    write_d      = pick_d && d_write;
                    wait_cnt_d   = '0;
                    busy_d       = 1'b1;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                busy_d = 1'b1;
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = RESP;
                    if (grant_d_q) begin
                        d_ack_d = 1'b1;
                        if (read_q) begin
                            d_rdata_d = readdata;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = readdata;
                    end
                end else if (timed_out) begin
                    // Abort a stuck slave: complete the handshake with zero data.
                    read_d        = 1'b0;
                    write_d       = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                    if (grant_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = 32'h0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = 32'h0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_d_q     <= 1'b0;
            last_d_q      <= 1'b1;
            wait_cnt_q    <= '0;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            i_ack_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_ack_q       <= 1'b0;
            d_rdata_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_d_q     <= grant_d_d;
            last_d_q      <= last_d_d;
            wait_cnt_q    <= wait_cnt_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            i_ack_q       <= i_ack_d;
            i_rdata_q     <= i_rdata_d;
            d_ack_q       <= d_ack_d;
            d_rdata_q     <= d_rdata_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign i_ack       = i_ack_q;
    assign i_rdata     = i_rdata_q;
    assign d_ack       = d_ack_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: instance A is round-robin with a long timeout,
// instance B is fixed-priority with WAIT_TIMEOUT=4; both share the same stimulus.
module tb_avalon_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req, d_req, d_write, waitrequest;
    logic [31:0] i_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_be;

    logic        a_i_ack, a_d_ack, a_read, a_write, a_busy, a_terr;
    logic [31:0] a_i_rdata, a_d_rdata, a_address, a_writedata;
    logic [3:0]  a_byteenable;
    logic        b_i_ack, b_d_ack, b_read, b_write, b_busy, b_terr;
    logic [31:0] b_i_rdata, b_d_rdata, b_address, b_writedata;
    logic [3:0]  b_byteenable;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          port_d;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    avalon_bus_arbiter #(.ROUND_ROBIN(1), .WAIT_TIMEOUT(255)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_be), .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .address(a_address), .read(a_read), .write(a_write), .writedata(a_writedata),
        .byteenable(a_byteenable), .readdata(readdata), .waitrequest(waitrequest),
        .busy(a_busy), .timeout_err(a_terr)
    );

    avalon_bus_arbiter #(.ROUND_ROBIN(0), .WAIT_TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_be), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .address(b_address), .read(b_read), .write(b_write), .writedata(b_writedata),
        .byteenable(b_byteenable), .readdata(readdata), .waitrequest(waitrequest),
        .busy(b_busy), .timeout_err(b_terr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; readdata = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Waits (bounded) for an ack on instance A (sel_b=0) or B (sel_b=1).
    task automatic wait_ack(input bit sel_b, input int budget, output bit got,
                            output bit port_d, output logic [31:0] rdata, output bit overlap);
        logic ia, da, rd, wr;
        got = 1'b0; port_d = 1'b0; rdata = '0; overlap = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            ia = sel_b ? b_i_ack : a_i_ack;
            da = sel_b ? b_d_ack : a_d_ack;
            rd = sel_b ? b_read  : a_read;
            wr = sel_b ? b_write : a_write;
            if ((rd && wr) || (ia && da)) overlap = 1'b1;
            if (ia || da) begin
                got    = 1'b1;
                port_d = da;
                rdata  = da ? (sel_b ? b_d_rdata : a_d_rdata) : (sel_b ? b_i_rdata : a_i_rdata);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; waitrequest = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; readdata = '0;
        #1;
        checks++;
        if ({a_read, a_write, a_i_ack, a_d_ack, a_busy, a_terr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {a_read, a_write, a_i_ack, a_d_ack, a_busy, a_terr});
        end
        checks++;
        if ({a_address, a_writedata, a_byteenable, a_i_rdata, a_d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h be=%h irdata=%h drdata=%h expected all 0",
                     a_address, a_writedata, a_byteenable, a_i_rdata, a_d_rdata);
        end
        $display("reset: outputs checked with reset low");
        do_reset();
    endtask

    task automatic test_single_fetch();
        exp_t e;
        do_reset();
        i_req = 1'b1; i_addr = 32'hBFC00000; waitrequest = 1'b0; readdata = 32'h24420001;
        exp_q.push_back('{port_d: 1'b0, rdata: 32'h24420001});
        tick();
        i_req = 1'b0;
        checks++;
        if ({a_read, a_write, a_address, a_byteenable, a_busy} !== {1'b1, 1'b0, 32'hBFC00000, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL fetch_strobe: rd=%b wr=%b addr=%h be=%h busy=%b expected rd=1 wr=0 addr=bfc00000 be=f busy=1",
                     a_read, a_write, a_address, a_byteenable, a_busy);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({a_read, a_i_ack, a_d_ack, a_busy, a_i_rdata} !== {1'b0, 1'b1, 1'b0, 1'b1, e.rdata}) begin
            errors++;
            $display("FAIL fetch_ack: rd=%b iack=%b dack=%b busy=%b irdata=%h expected rd=0 iack=1 dack=0 busy=1 irdata=%h",
                     a_read, a_i_ack, a_d_ack, a_busy, a_i_rdata, e.rdata);
        end
        tick();
        checks++;
        if ({a_i_ack, a_d_ack, a_busy} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_after: iack=%b dack=%b busy=%b expected 000", a_i_ack, a_d_ack, a_busy);
        end
        $display("single_fetch: addr=bfc00000 irdata=%h", a_i_rdata);
    endtask

    task automatic test_stalled_write();
        exp_t e;
        bit got, pd, ov;
        logic [31:0] rd;
        int acks;
        do_reset();
        // Prime d_rdata with a known value so an illegal capture on write is visible.
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h2000; readdata = 32'h55AA1234;
        exp_q.push_back('{port_d: 1'b1, rdata: 32'h55AA1234});
        tick();
        d_req = 1'b0;
        wait_ack(1'b0, 10, got, pd, rd, ov);
        e = exp_q.pop_front();
        checks++;
        if (!got || pd !== e.port_d || rd !== e.rdata) begin
            errors++;
            $display("FAIL prime_read: got=%b port_d=%b rdata=%h expected got=1 port_d=1 rdata=%h", got, pd, rd, e.rdata);
        end
        tick();
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        waitrequest = 1'b1; readdata = 32'hFFFFFFFF;
        exp_q.push_back('{port_d: 1'b1, rdata: 32'h55AA1234});
        tick();
        d_req = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            if (a_d_ack) acks++;
            checks++;
            if ({a_write, a_read, a_address, a_writedata, a_byteenable} !== {1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 4'b0011}) begin
                errors++;
                $display("FAIL write_hold[%0d]: wr=%b rd=%b addr=%h wdata=%h be=%b expected wr=1 rd=0 addr=1000 wdata=deadbeef be=0011",
                         c, a_write, a_read, a_address, a_writedata, a_byteenable);
            end
            if (c == 5) waitrequest = 1'b0;
            else tick();
        end
        tick();
        e = exp_q.pop_front();
        if (a_d_ack) acks++;
        checks++;
        if ({a_write, a_d_ack, a_i_ack, a_d_rdata} !== {1'b0, 1'b1, 1'b0, e.rdata}) begin
            errors++;
            $display("FAIL write_ack: wr=%b dack=%b iack=%b drdata=%h expected wr=0 dack=1 iack=0 drdata=%h",
                     a_write, a_d_ack, a_i_ack, a_d_rdata, e.rdata);
        end
        tick();
        if (a_d_ack) acks++;
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL write_ack_count: got %0d acks expected 1", acks);
        end
        $display("stalled_write: addr=1000 wdata=deadbeef acks=%0d drdata=%h", acks, a_d_rdata);
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit got, pd, ov;
        logic [31:0] rd;
        logic [31:0] vals[4];
        vals[0] = 32'hA0000001; vals[1] = 32'hB0000002; vals[2] = 32'hA0000003; vals[3] = 32'hB0000004;
        do_reset();
        for (int n = 0; n < 4; n++) exp_q.push_back('{port_d: n[0], rdata: vals[n]});
        i_req = 1'b1; i_addr = 32'h0040_0000; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h1000_0000;
        waitrequest = 1'b0; readdata = vals[0];
        for (int n = 0; n < 4; n++) begin
            wait_ack(1'b0, 10, got, pd, rd, ov);
            e = exp_q.pop_front();
            checks++;
            if (!got || ov || pd !== e.port_d || rd !== e.rdata) begin
                errors++;
                $display("FAIL rr_txn[%0d]: got=%b overlap=%b port_d=%b rdata=%h expected got=1 overlap=0 port_d=%b rdata=%h",
                         n, got, ov, pd, rd, e.port_d, e.rdata);
            end
            $display("round_robin: txn %0d port=%s rdata=%h", n, pd ? "D" : "I", rd);
            if (n < 3) readdata = vals[n+1];
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        bit got, pd, ov;
        logic [31:0] rd;
        do_reset();
        for (int n = 0; n < 3; n++) exp_q.push_back('{port_d: 1'b1, rdata: 32'hD0D0_0000 + n});
        exp_q.push_back('{port_d: 1'b0, rdata: 32'h1111_0003});
        i_req = 1'b1; d_req = 1'b1; d_write = 1'b0; waitrequest = 1'b0; readdata = 32'hD0D0_0000;
        for (int n = 0; n < 4; n++) begin
            wait_ack(1'b1, 10, got, pd, rd, ov);
            e = exp_q.pop_front();
            checks++;
            if (!got || ov || pd !== e.port_d || rd !== e.rdata) begin
                errors++;
                $display("FAIL fp_txn[%0d]: got=%b overlap=%b port_d=%b rdata=%h expected got=1 overlap=0 port_d=%b rdata=%h",
                         n, got, ov, pd, rd, e.port_d, e.rdata);
            end
            $display("fixed_priority: txn %0d port=%s rdata=%h", n, pd ? "D" : "I", rd);
            if (n < 2) readdata = 32'hD0D0_0000 + n + 1;
            if (n == 2) begin
                d_req = 1'b0;
                readdata = 32'h1111_0003;
            end
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        exp_t e;
        bit got, pd, ov;
        logic [31:0] rd;
        int cnt;
        logic sd_ack, sterr;
        logic [31:0] sd_rdata;
        do_reset();
        checks++;
        if (b_terr !== 1'b0) begin
            errors++;
            $display("FAIL to_err_init: got %b expected 0", b_terr);
        end
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h3000; waitrequest = 1'b0; readdata = 32'h11112222;
        exp_q.push_back('{port_d: 1'b1, rdata: 32'h11112222});
        tick();
        d_req = 1'b0;
        wait_ack(1'b1, 10, got, pd, rd, ov);
        e = exp_q.pop_front();
        checks++;
        if (!got || pd !== e.port_d || rd !== e.rdata) begin
            errors++;
            $display("FAIL to_prime: got=%b port_d=%b rdata=%h expected got=1 port_d=1 rdata=%h", got, pd, rd, e.rdata);
        end
        tick();
        d_req = 1'b1; waitrequest = 1'b1; readdata = 32'h12345678;
        exp_q.push_back('{port_d: 1'b1, rdata: 32'h0});
        tick();
        d_req = 1'b0;
        cnt = b_read ? 1 : 0;
        sd_ack = 1'b0; sd_rdata = '1; sterr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (b_read) cnt++;
            else begin
                sd_ack = b_d_ack; sd_rdata = b_d_rdata; sterr = b_terr;
                break;
            end
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL to_strobe_len: got %0d cycles expected 4", cnt);
        end
        e = exp_q.pop_front();
        checks++;
        if ({sd_ack, sterr, sd_rdata} !== {1'b1, 1'b1, e.rdata}) begin
            errors++;
            $display("FAIL to_abort: dack=%b err=%b drdata=%h expected dack=1 err=1 drdata=%h", sd_ack, sterr, sd_rdata, e.rdata);
        end
        tick();
        checks++;
        if ({b_terr, b_d_ack} !== 2'b10) begin
            errors++;
            $display("FAIL to_sticky: err=%b dack=%b expected err=1 dack=0", b_terr, b_d_ack);
        end
        waitrequest = 1'b0; readdata = 32'hCAFEF00D; i_req = 1'b1; i_addr = 32'h0000_0100;
        exp_q.push_back('{port_d: 1'b0, rdata: 32'hCAFEF00D});
        wait_ack(1'b1, 10, got, pd, rd, ov);
        i_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got || pd !== e.port_d || rd !== e.rdata || b_terr !== 1'b1) begin
            errors++;
            $display("FAIL to_next: got=%b port_d=%b rdata=%h err=%b expected got=1 port_d=0 rdata=%h err=1",
                     got, pd, rd, b_terr, e.rdata);
        end
        $display("timeout: strobe cycles=%0d err=%b next rdata=%h", cnt, b_terr, rd);
        tick();
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        bit got, pd, ov;
        logic [31:0] rd;
        int acks;
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_2000; waitrequest = 1'b1; readdata = 32'h77777777;
        tick();
        checks++;
        if (a_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: read=%b expected 1", a_read);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({a_read, a_busy, a_address} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_async: read=%b busy=%b addr=%h expected read=0 busy=0 addr=0", a_read, a_busy, a_address);
        end
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (a_i_ack || a_d_ack) acks++;
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (a_i_ack || a_d_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL rst_no_ack: got %0d acks expected 0", acks);
        end
        i_req = 1'b1; d_req = 1'b1; d_write = 1'b0; waitrequest = 1'b0; readdata = 32'h88889999;
        exp_q.push_back('{port_d: 1'b0, rdata: 32'h88889999});
        wait_ack(1'b0, 10, got, pd, rd, ov);
        i_req = 1'b0; d_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got || pd !== e.port_d || rd !== e.rdata) begin
            errors++;
            $display("FAIL rst_first_grant: got=%b port_d=%b rdata=%h expected got=1 port_d=0 rdata=%h", got, pd, rd, e.rdata);
        end
        $display("reset_mid_grant: first grant after release port=%s", pd ? "D" : "I");
        tick();
        tick();
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_single_fetch();
        test_stalled_write();
        test_round_robin();
        test_fixed_priority();
        test_timeout();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-requester arbiter sharing the single Avalon memory-mapped master port of mips_cpu_bus between instruction fetch (port I) and data load/store (port D).
- Sequences one bus transaction at a time and honours waitrequest.
- Returns a registered response (ack, rdata) to the winning requester.
- Round-robin fairness; optional waitrequest timeout reports a stuck slave.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, port D wins.
- WAIT_TIMEOUT, 255, max consecutive waitrequest cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction requester wants a read (fetch is read-only).
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  32  fetched word.
- d_req  in  1  data requester wants a transaction.
- d_write  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_byteenable  in  4  byte lanes.
- d_ack  out  1  one-cycle pulse; d_rdata valid for reads.
- d_rdata  out  32  read data.
- address  out  32  Avalon address.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte enables; 4'b1111 for fetches.
- readdata  in  32  Avalon read data, valid in the cycle waitrequest is low.
- waitrequest  in  1  Avalon stall.
- busy  out  1  high in GRANT or RESP.
- timeout_err  out  1  sticky; set on timeout abort, cleared only by reset.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; all outputs 0, including address, writedata and byteenable; last_grant=D, so port I wins first contention; wait counter=0.
- A reset mid-transaction drops read/write immediately and issues no ack.
- All outputs are registered.
- State machine: IDLE -> GRANT -> RESP -> IDLE.
- IDLE: sample requests on the rising edge.
  - Only one req high: grant that port.
  - Both high with ROUND_ROBIN=1: grant the port not equal to last_grant.
  - Both high with ROUND_ROBIN=0: grant D.
  - On grant: latch address/wdata/byteenable/direction into the bus registers, assert read or write, update last_grant, go to GRANT.
- GRANT: hold all bus outputs stable while waitrequest=1; wait counter increments each stalled cycle.
  - waitrequest=0 at a rising edge: deassert read/write; for reads, capture readdata into the granted port's rdata; assert that port's ack; go to RESP.
  - Timeout (WAIT_TIMEOUT!=0, counter reaches WAIT_TIMEOUT while still stalled): deassert strobes, set timeout_err, assert ack with rdata=32'h0, go to RESP.
- RESP: ack high for exactly this one cycle.
  - Requests are ignored in RESP; the requester must drop or replace req by the cycle after ack.
  - Next state IDLE; counter cleared.
- Minimum latency: req sampled at edge k; bus strobe visible after k; waitrequest=0 at edge k+1 gives ack high after k+1 and low after k+2. Back-to-back transactions need 3 cycles each.
- Writes: d_rdata holds its previous value; d_ack still pulses.
- read and write are never both high.
- Non-granted ack is always 0; i_ack and d_ack are never both high.
- A req deasserted while its port is granted does not abort the transaction; the ack is still issued.

Test Plan:
- Single fetch: i_req=1, i_addr=32'hBFC00000, slave waitrequest=0, readdata=32'h24420001 -> read=1 and address=BFC00000 for 1 cycle; i_ack one cycle later with i_rdata=24420001; d_ack stays 0.
- Stalled write: d_req=1, d_write=1, d_addr=0x1000, d_wdata=0xDEADBEEF, be=4'b0011, waitrequest high 5 cycles -> write, address, writedata and byteenable stable for 6 cycles; d_ack once; d_rdata unchanged.
- Contention, ROUND_ROBIN=1: both req held for 4 transactions from reset -> grant order I, D, I, D; never two acks in the same cycle.
- Contention, ROUND_ROBIN=0: both req held -> D granted every time until d_req drops, then I.
- Timeout, WAIT_TIMEOUT=4: waitrequest stuck high -> strobe drops after 4 stalled cycles; timeout_err=1 (sticky); d_ack with d_rdata=0; next request still served.
- Reset mid-GRANT (reset low with read=1) -> read=0 immediately without a clock edge; no ack; after release the first contention grants I.
